// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neural-network layers.
// The ReLU enable is supplied by the caller (see LAYER_SEQ_RELU_EN in layer_sequencer).
package nn_pkg;

  localparam int RES_DEF   = 8;
  localparam int ACC_W_DEF = 4 * RES_DEF - 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // z arrives sign-extended to 64 bits so one helper serves every width;
  // the caller keeps only the low RES bits of the result, which is what makes it wrap.
  function automatic logic [63:0] out_slice(input logic signed [63:0] z,
                                            input int                 lsb,
                                            input bit                 relu);
    if (relu && (z < 0)) return '0;
    return z >>> lsb;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// Accumulation wraps modulo 2^ACC_W.
module mac_unit #(
  parameter int RES   = 8,
  parameter int ACC_W = 4 * RES - 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [RES-1:0]   a,
  input  logic signed [RES-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*RES-1:0] prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACC_W'(prod);
  end

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/layer_sequencer.sv
// One fully-connected layer computed neuron by neuron through a single MAC.
// Define LAYER_SEQ_RELU_EN to clamp negative neuron results to zero (hidden layers).
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 10,
  parameter int RES     = RES_DEF,
  parameter int ACC_W   = 4 * RES - 5,
  parameter int OUT_LSB = ACC_W - RES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(N_IN)-1:0]         in_addr,
  input  logic [RES-1:0]                  in_data,
  output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
  input  logic [RES-1:0]                  w_data,
  output logic [$clog2(N_OUT)-1:0]        b_addr,
  input  logic [RES-1:0]                  b_data,
  output logic                            out_we,
  output logic [$clog2(N_OUT)-1:0]        out_addr,
  output logic [RES-1:0]                  out_data
);

  localparam int IA_W = $clog2(N_IN);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int OA_W = $clog2(N_OUT);
  localparam logic [IA_W-1:0] K_LAST = IA_W'(N_IN - 1);
  localparam logic [OA_W-1:0] J_LAST = OA_W'(N_OUT - 1);

`ifdef LAYER_SEQ_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  state_e            state_d, state_q;
  logic [IA_W-1:0]   k_d, k_q;
  logic [OA_W-1:0]   j_d, j_q;
  logic [WA_W-1:0]   wa_d, wa_q;
  logic              en_d, en_q;
  logic              mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] z;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    wa_d    = wa_q;
    mac_clr = 1'b0;
    out_we  = 1'b0;
    // Product of this cycle's addresses lands one cycle later, after the memory read.
    en_d    = (state_q == ST_FETCH);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          k_d     = '0;
          j_d     = '0;
          wa_d    = '0;
          mac_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        k_d  = k_q + IA_W'(1);
        wa_d = wa_q + WA_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        out_we = 1'b1;
        if (j_q == J_LAST) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + OA_W'(1);
          mac_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      wa_q    <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      wa_q    <= wa_d;
      en_q    <= en_d;
    end
  end

  mac_unit #(
    .RES   (RES),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (en_q),
    .a     ($signed(in_data)),
    .b     ($signed(w_data)),
    .acc   (acc)
  );

  // The weight address runs on continuously across neurons, giving j*N_IN+k without a multiplier.
  assign in_addr  = k_q;
  assign w_addr   = wa_q;
  assign b_addr   = j_q;
  assign out_addr = j_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  assign z        = acc + ACC_W'($signed(b_data));
  assign out_data = (state_q == ST_WRITE) ? RES'(out_slice(64'(z), OUT_LSB, RELU_ON)) : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with N_IN=4, N_OUT=2, RES=8, OUT_LSB=8.
// Expected writes/done cycles are queued at start; a negedge monitor pops and compares.
module tb_layer_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int NEUR  = N_IN + 2;

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, out_we;
  logic [1:0] in_addr;
  logic [2:0] w_addr;
  logic [0:0] b_addr, out_addr;
  logic [7:0] in_data, w_data, b_data, out_data;

  logic [7:0] act  [N_IN];
  logic [7:0] wt   [N_IN*N_OUT];
  logic [7:0] bias [N_OUT];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  wr_t wq[$];
  int  dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency memories
  always @(posedge clk) begin
    in_data <= act[in_addr];
    w_data  <= wt[w_addr];
  end
  assign b_data = bias[b_addr];

  layer_sequencer #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .RES     (8),
    .OUT_LSB (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (!reset) begin
      if (out_we) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write got addr=%0d data=%0h expected no write (cycle %0d)",
                   out_addr, out_data, cyc);
        end else begin
          e = wq.pop_front();
          check("wr_addr", 64'(out_addr), 64'(e.addr));
          check("wr_data", 64'(out_data), 64'(e.data));
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          dc = dq.pop_front();
          check("done_cycle", 64'(cyc), 64'(dc));
          check("busy_at_done", 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] b);
    for (int i = 0; i < N_IN; i++) act[i] = a;
    for (int i = 0; i < N_IN * N_OUT; i++) wt[i] = (i < N_IN) ? w0 : w1;
    for (int i = 0; i < N_OUT; i++) bias[i] = b;
  endtask

  task automatic issue_start(input logic [7:0] e0, input logic [7:0] e1);
    int s;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    wq.push_back('{0, e0, s + NEUR});
    wq.push_back('{1, e1, s + 2 * NEUR});
    dq.push_back(s + 2 * NEUR + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((wq.size() > 0 || dq.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(wq.size() + dq.size()), 64'd0);
    wq.delete();
    dq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass(input string name, input logic [7:0] a, input logic [7:0] w0,
                          input logic [7:0] w1, input logic [7:0] b,
                          input logic [7:0] e0, input logic [7:0] e1);
    load(a, w0, w1, b);
    issue_start(e0, e1);
    wait_drain(name);
  endtask

  initial begin
    logic [7:0] neg_exp;
`ifdef LAYER_SEQ_RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'hC0;
`endif
    reset = 1'b1;
    start = 1'b0;
    load(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_we", 64'(out_we), 64'd0);
    check("rst_in_addr", 64'(in_addr), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_b_addr", 64'(b_addr), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 4*64*64 = 16384 -> >>8 = 64
    run_pass("pass_basic", 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64);
    // neuron 1: -16384 -> 0xC0, or 0 under ReLU
    run_pass("pass_negative", 8'd64, 8'd64, 8'hC0, 8'd0, 8'd64, neg_exp);
    // 16384 + 100 = 16484 = 0x4064 -> 64
    run_pass("pass_bias", 8'd64, 8'd64, 8'd64, 8'd100, 8'd64, 8'd64);
    // 4*127*127 = 64516 = 0xFC04 -> 0xFC, wraps
    run_pass("pass_wrap", 8'd127, 8'd127, 8'd127, 8'd0, 8'hFC, 8'hFC);

    // Reset in the third FETCH cycle
    load(8'd64, 8'd64, 8'd64, 8'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_out_we", 64'(out_we), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    run_pass("pass_after_reset", 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64);

    // Start pulses while busy must be ignored
    load(8'd64, 8'd64, 8'd64, 8'd0);
    issue_start(8'd64, 8'd64);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("pass_start_busy");
    repeat (15) @(negedge clk);
    check("idle_after_busy_start", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Time-multiplexed controller for one fully-connected layer of the digit-recognition network. It replaces N_OUT parallel combinational neurons with a single pipelined multiply-accumulate unit. For each output neuron it reads every input activation and weight from synchronous memories, accumulates, adds the bias, truncates to RES bits and writes the result to an output buffer. It sits between the activation/weight/bias memories and the next layer's input buffer, and is started by the top-level network controller.

## Interface
Parameters:
- N_IN, 784, inputs per neuron
- N_OUT, 10, neurons in the layer
- RES, 8, data width (signed two's complement)
- ACC_W, 4*RES-5, accumulator width
- OUT_LSB, ACC_W-RES, lowest bit of the accumulator taken as output

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse in DONE
- in_addr  out  clog2(N_IN)  activation read address
- in_data  in  RES  activation; valid 1 cycle after in_addr
- w_addr  out  clog2(N_IN*N_OUT)  weight address = j*N_IN + k
- w_data  in  RES  weight; valid 1 cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias address = current neuron j; held for the whole neuron
- b_data  in  RES  bias; stable by the WRITE cycle
- out_we  out  1  output write strobe
- out_addr  out  clog2(N_OUT)  output index j
- out_data  out  RES  neuron result

## Operation
- States:
  - IDLE: start=1 goes to FETCH with j=0, k=0 and the accumulator cleared.
  - FETCH: issues addresses for k=0..N_IN-1, one per cycle. After k=N_IN-1 it goes to DRAIN.
  - DRAIN: accumulates the final product, then goes to WRITE.
  - WRITE: out_we=1. If j<N_OUT-1, increments j, clears the accumulator and returns to FETCH. If j=N_OUT-1, goes to DONE.
  - DONE: returns to IDLE.
- MAC pipeline:
  - Each product is in_data*w_data (2*RES bits, signed), sign-extended to ACC_W and added the cycle after its addresses are issued.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Output:
  - z = acc + sign-extended b_data.
  - out_data = z[OUT_LSB +: RES]. Bits above the slice are discarded, so the result wraps.
- Addresses are don't-care outside FETCH.
- start while busy is ignored.
- Reset mid-pass: immediate return to IDLE with all outputs at their reset values. No further writes occur and partial results are abandoned.

## Timing
- Reset values: busy=0, done=0, out_we=0, in_addr=0, w_addr=0, b_addr=0, out_addr=0, out_data=0, accumulator=0.
- Start accepted at edge T. The first FETCH cycle is T+1.
- Each neuron takes N_IN+2 cycles (N_IN FETCH, 1 DRAIN, 1 WRITE).
- Neuron j is written in cycle T + (j+1)*(N_IN+2).
- done follows in the next cycle. Total latency from start to done is N_OUT*(N_IN+2)+1 cycles.
- busy falls together with done going low. start is re-accepted in the first IDLE cycle after DONE.
- The memories must have exactly 1-cycle read latency.

## Configuration
- LAYER_SEQ_RELU_EN defined: if z is negative, out_data=0 (ReLU applied before truncation). This is used for hidden layers.
- LAYER_SEQ_RELU_EN undefined: the raw truncated slice is written. This is used for the output/logit layer.

## Structure
- Package nn_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, WRITE, DONE)
  - the RES and ACC_W defaults
  - a function computing the output slice and ReLU
- Sub-module mac_unit contains the registered signed multiply-accumulate, with clear and enable inputs and an ACC_W-bit accumulator output. layer_sequencer holds the FSM, the counters j and k, and the output logic.

## Test plan
Bench parameters are N_IN=4, N_OUT=2, RES=8, OUT_LSB=8, with memory models of 1-cycle latency.
- All inputs 64, all weights 64, bias 0 -> out_data=64 for j=0,1; done exactly 13 cycles after the start edge; out_we high in cycles 6 and 12.
- Inputs 64, weights for neuron 1 = -64 -> neuron 1 writes 0xC0 with the macro off, and 0x00 with LAYER_SEQ_RELU_EN.
- Inputs 64, weights 64, bias 100 -> z=16484, out_data=64.
- Inputs 127, weights 127 -> z=64516, out_data=0xFC; the result wraps with no saturation.
- Assert reset in cycle 3 of FETCH -> busy, done and out_we are 0 immediately, with no write. A new start then gives correct results with the full 13-cycle latency.
- Pulse start again while busy -> ignored; exactly N_OUT writes and one done pulse.
